// File: rtl/ps2_kbd_wb.sv
// PS/2 keyboard receiver with a 16-entry scan-code FIFO behind a Wishbone slave.
// DATA register (ADDR[2]=0) pops one byte per read; STATUS (ADDR[2]=1) exposes flags and count.
module ps2_kbd_wb #(
    parameter int FIFO_AW        = 4,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        RSTN,
    input  logic        PS2C,
    input  logic        PS2D,
    input  logic        STB,
    input  logic        WE,
    input  logic [31:0] ADDR,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK,
    output logic        kbd_irq
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int FW    = $clog2(FILTER_LEN + 1);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          r_c_s1, r_c_s2, r_d_s1, r_d_s2;
    logic          r_cf, r_cf_d;
    logic [FW-1:0] r_fcnt;
    state_t        r_state, w_state_nxt;
    logic [2:0]    r_bcnt;
    logic [7:0]    r_sh;
    logic          r_par;
    logic [TW-1:0] r_tcnt;
    logic [7:0]    r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wp, r_rp;
    logic [FIFO_AW:0]   r_cnt;
    logic          r_ovf, r_perr, r_ferr, r_served, r_ack, r_irq;
    logic [31:0]   r_dat;

    logic w_fall, w_push, w_perr_set, w_ferr_set;
    logic w_full, w_nempty, w_acc, w_pop, w_wr_en, w_ovf_set;
    logic [2:0] w_clr;
    logic w_unused;

    assign w_unused = ^{ADDR[31:3], ADDR[1:0], DAT_I[31:5], DAT_I[1:0]};

    // Input synchronisers and clock glitch filter
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_c_s1 <= 1'b1;
            r_c_s2 <= 1'b1;
            r_d_s1 <= 1'b1;
            r_d_s2 <= 1'b1;
            r_cf   <= 1'b1;
            r_cf_d <= 1'b1;
            r_fcnt <= '0;
        end else begin
            r_c_s1 <= PS2C;
            r_c_s2 <= r_c_s1;
            r_d_s1 <= PS2D;
            r_d_s2 <= r_d_s1;
            r_cf_d <= r_cf;
            if (r_c_s2 == r_cf) begin
                r_fcnt <= '0;
            end else if (r_fcnt == FMAX) begin
                r_cf   <= r_c_s2;
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    assign w_fall = r_cf_d & ~r_cf;

    // Deframer next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_perr_set  = 1'b0;
        w_ferr_set  = 1'b0;
        if (r_state != S_IDLE && !w_fall && r_tcnt == TMAX) begin
            w_state_nxt = S_IDLE;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!r_d_s2) w_state_nxt = S_DATA;
                S_DATA:   if (r_bcnt == 3'd7) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    if (!r_d_s2)             w_ferr_set = 1'b1;
                    else if (^{r_sh, r_par}) w_push     = 1'b1;
                    else                     w_perr_set = 1'b1;
                end
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= S_IDLE;
            r_bcnt  <= '0;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE || w_fall) r_tcnt <= '0;
            else                             r_tcnt <= r_tcnt + 1'b1;
            if (w_fall && r_state == S_IDLE)      r_bcnt <= '0;
            else if (w_fall && r_state == S_DATA) r_bcnt <= r_bcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fall && r_state == S_DATA)   r_sh  <= {r_d_s2, r_sh[7:1]};
        if (w_fall && r_state == S_PARITY) r_par <= r_d_s2;
        if (w_wr_en)                       r_mem[r_wp] <= r_sh;
    end

    // Bus decode, FIFO control and flags
    assign w_full    = (r_cnt == (FIFO_AW+1)'(DEPTH));
    assign w_nempty  = (r_cnt != '0);
    assign w_acc     = STB & ~r_served;
    assign w_pop     = w_acc & ~WE & ~ADDR[2] & w_nempty;
    assign w_wr_en   = w_push & (~w_full | w_pop);
    assign w_ovf_set = w_push & w_full & ~w_pop;
    assign w_clr     = (w_acc & WE & ADDR[2]) ? DAT_I[4:2] : 3'b000;

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
            r_served <= 1'b0;
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_en) r_wp <= r_wp + 1'b1;
            if (w_pop)   r_rp <= r_rp + 1'b1;
            if (w_wr_en && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_wr_en && w_pop) r_cnt <= r_cnt - 1'b1;
            r_ovf  <= w_ovf_set  | (r_ovf  & ~w_clr[0]);
            r_perr <= w_perr_set | (r_perr & ~w_clr[1]);
            r_ferr <= w_ferr_set | (r_ferr & ~w_clr[2]);
            r_irq  <= w_nempty;
            r_ack  <= w_acc;
            if (!STB)       r_served <= 1'b0;
            else if (w_acc) r_served <= 1'b1;
            if (w_acc) begin
                if (WE)
                    r_dat <= '0;
                else if (ADDR[2])
                    r_dat <= {22'd0, 5'(r_cnt), r_ferr, r_perr, r_ovf, w_full, w_nempty};
                else if (w_nempty)
                    r_dat <= {23'd0, 1'b1, r_mem[r_rp]};
                else
                    r_dat <= '0;
            end
        end
    end

    assign DAT_O   = r_dat;
    assign ACK     = r_ack;
    assign kbd_irq = r_irq;
endmodule

// File: tb/tb_ps2_kbd_wb.sv
// Directed bench for ps2_kbd_wb: bit-banged PS/2 frames and Wishbone register accesses.
module tb_ps2_kbd_wb;
    localparam int HALF = 40;

    logic        clk = 1'b0;
    logic        RSTN, PS2C, PS2D, STB, WE;
    logic [31:0] ADDR, DAT_I, DAT_O;
    logic        ACK, kbd_irq;

    int n_run  = 0;
    int n_fail = 0;

    always #20 clk = ~clk;

    ps2_kbd_wb #(.FIFO_AW(4), .FILTER_LEN(4), .TIMEOUT_CYCLES(400)) dut (
        .clk(clk), .RSTN(RSTN), .PS2C(PS2C), .PS2D(PS2D), .STB(STB), .WE(WE),
        .ADDR(ADDR), .DAT_I(DAT_I), .DAT_O(DAT_O), .ACK(ACK), .kbd_irq(kbd_irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        PS2D = b;
        wait_clks(HALF);
        PS2C = 1'b0;
        wait_clks(HALF);
        PS2C = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop,
                              input logic glitch);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            ps2_bit(d[i]);
            if (glitch && i == 2) begin
                wait_clks(5);
                PS2C = 1'b0;
                wait_clks(2);
                PS2C = 1'b1;
            end
        end
        ps2_bit(~^d ^ bad_par);
        ps2_bit(stop);
        PS2D = 1'b1;
        wait_clks(2 * HALF);
    endtask

    task automatic bus(input logic we, input logic a2, input logic [31:0] wd,
                       input string tag, output logic [31:0] rd);
        bit got = 0;
        STB   = 1'b1;
        WE    = we;
        ADDR  = a2 ? 32'h4 : 32'h0;
        DAT_I = wd;
        for (int k = 0; k < 8 && !got; k++) begin
            wait_clks(1);
            if (ACK) got = 1;
        end
        if (!got) chk({tag, "_ack_timeout"}, 32'd0, 32'd1);
        rd = DAT_O;
        wait_clks(1);
        chk({tag, "_ack_width"}, {31'd0, ACK}, 32'd0);
        STB = 1'b0;
        WE  = 1'b0;
        wait_clks(1);
    endtask

    task automatic rd_chk(input logic a2, input string tag, input logic [31:0] exp);
        logic [31:0] d;
        bus(1'b0, a2, 32'd0, tag, d);
        chk(tag, d, exp);
    endtask

    task automatic wr_status(input logic [31:0] v, input string tag);
        logic [31:0] d;
        bus(1'b1, 1'b1, v, tag, d);
    endtask

    initial begin
        logic [31:0] hold_dat;
        int acks;
        RSTN = 1'b0; PS2C = 1'b1; PS2D = 1'b1;
        STB = 1'b0; WE = 1'b0; ADDR = '0; DAT_I = '0;
        wait_clks(3);
        chk("rst_ack", {31'd0, ACK}, 32'd0);
        chk("rst_dat", DAT_O, 32'd0);
        chk("rst_irq", {31'd0, kbd_irq}, 32'd0);
        RSTN = 1'b1;
        wait_clks(2);

        rd_chk(1'b1, "st_reset", 32'h0);
        rd_chk(1'b0, "dat_reset", 32'h0);
        chk("irq_reset", {31'd0, kbd_irq}, 32'd0);

        // good frame with a short clock glitch that the filter must reject
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
        chk("irq_1c", {31'd0, kbd_irq}, 32'd1);
        rd_chk(1'b1, "st_1c", 32'h21);
        rd_chk(1'b0, "dat_1c", 32'h11C);
        rd_chk(1'b1, "st_pop", 32'h0);
        chk("irq_pop", {31'd0, kbd_irq}, 32'd0);

        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        rd_chk(1'b1, "st_perr", 32'h08);
        wr_status(32'h08, "clr_perr");
        rd_chk(1'b1, "st_perr_clr", 32'h0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        rd_chk(1'b1, "st_ferr", 32'h10);
        wr_status(32'h10, "clr_ferr");
        rd_chk(1'b1, "st_ferr_clr", 32'h0);

        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
        rd_chk(1'b1, "st_full", 32'h207);
        for (int i = 0; i < 16; i++) rd_chk(1'b0, "dat_fifo", 32'h100 + 32'(i));
        rd_chk(1'b0, "dat_empty", 32'h0);
        rd_chk(1'b1, "st_ovf", 32'h4);
        wr_status(32'h04, "clr_ovf");
        rd_chk(1'b1, "st_ovf_clr", 32'h0);

        // partial frame abandoned long enough to time out
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
        PS2D = 1'b1;
        wait_clks(500);
        rd_chk(1'b1, "st_timeout", 32'h0);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        rd_chk(1'b0, "dat_f0", 32'h1F0);

        send_frame(8'h55, 1'b0, 1'b1, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b1, 1'b0);
        rd_chk(1'b1, "st_two", 32'h41);
        acks = 0;
        hold_dat = '0;
        STB = 1'b1; WE = 1'b0; ADDR = 32'h0;
        for (int k = 0; k < 5; k++) begin
            wait_clks(1);
            if (ACK) begin
                acks++;
                hold_dat = DAT_O;
            end
        end
        STB = 1'b0;
        wait_clks(1);
        chk("hold_acks", 32'(acks), 32'd1);
        chk("hold_dat", hold_dat, 32'h155);
        rd_chk(1'b1, "st_hold", 32'h21);

        // reset in the middle of a frame with one byte still queued
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        RSTN = 1'b0;
        wait_clks(2);
        chk("rst2_ack", {31'd0, ACK}, 32'd0);
        chk("rst2_dat", DAT_O, 32'd0);
        chk("rst2_irq", {31'd0, kbd_irq}, 32'd0);
        PS2D = 1'b1;
        RSTN = 1'b1;
        wait_clks(2 * HALF);
        rd_chk(1'b1, "st_rst2", 32'h0);
        send_frame(8'h3A, 1'b0, 1'b1, 1'b0);
        rd_chk(1'b0, "dat_3a", 32'h13A);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_kbd_wb.md
# ps2_kbd_wb

Wishbone slave that receives scan-code bytes from a PS/2 keyboard and presents them to the CPU through the intercon's Keyboard slot (slot 3). It synchronises and filters the raw PS2C/PS2D pins, deframes 11-bit PS/2 frames with parity/stop checking, and buffers received bytes in a FIFO. The CPU reads the bytes and a status word through a two-register window.

## Interface
- FIFO_AW, 4, log2 of FIFO depth (16 entries)
- FILTER_LEN, 8, consecutive equal PS2C samples needed to accept a level change
- TIMEOUT_CYCLES, 50000, idle clk cycles mid-frame before abort (2 ms at 25 MHz)

- clk  in  1  system clock, same as CPU (clk25)
- RSTN  in  1  asynchronous, active-low reset
- PS2C  in  1  raw PS/2 clock pin
- PS2D  in  1  raw PS/2 data pin
- STB  in  1  Wishbone strobe (Keyboard_STB)
- WE  in  1  write enable
- ADDR  in  32  byte address; only ADDR[2] decoded
- DAT_I  in  32  write data
- DAT_O  out  32  read data (Keyboard_DAT_O)
- ACK  out  1  one-cycle acknowledge (Keyboard_ACK)
- kbd_irq  out  1  high while FIFO non-empty

## Operation
- Input path: PS2C, PS2D each through 2-FF synchroniser. Filtered clock changes level only after FILTER_LEN consecutive equal synchronised samples. Falling edge of filtered clock samples synchronised PS2D.
- Deframer states: IDLE, DATA, PARITY, STOP.
  - IDLE: on edge, data=0 -> DATA (bit count 0); data=1 ignored.
  - DATA: shift in LSB first; after 8th bit -> PARITY.
  - PARITY: capture bit -> STOP.
  - STOP: valid iff stop=1 and XOR(8 data bits, parity)=1 (odd parity). Valid -> push byte. Parity bad -> set PERR, no push. Stop=0 -> set FERR, no push. Always -> IDLE.
  - Any non-IDLE state: no falling edge for TIMEOUT_CYCLES -> IDLE, partial byte discarded, no flag.
- FIFO: 2^FIFO_AW x 8 bits, count 0..2^FIFO_AW. Push when full without simultaneous pop: byte dropped, OVF set. Push and pop same cycle when full: both take effect, no OVF, count unchanged.
- Register map (ADDR[2]):
  - 0 DATA, read: [8]=valid, [7:0]=head byte, [31:9]=0; pops FIFO iff non-empty. Empty -> 0x0000_0000, no pop. Write: ACKed, ignored.
  - 1 STATUS, read: [0] non-empty, [1] full, [2] OVF, [3] PERR, [4] FERR, [9:5] count, rest 0. Write: DAT_I[4:2] write-1-to-clear OVF/PERR/FERR; set event in same cycle wins over clear.
- kbd_irq = non-empty, registered.

## Timing
- Reset (RSTN low, async): ACK=0, DAT_O=0, kbd_irq=0, FIFO empty, flags 0, deframer IDLE, filtered clock=1, timeout counter 0. Reset mid-frame discards the frame.
- Bus handshake: transaction accepted in the cycle STB is sampled high while not already served; ACK and DAT_O valid in the next cycle, ACK high exactly one cycle. No further ACK until STB sampled low at least one cycle (CPU holds STB through its wait state; prevents double pop). DAT_O holds its value until the next transaction.
- Pop / flag clear take effect in the ACK cycle; a STATUS read in the following transaction reflects them.
- Pin-to-edge latency: 2 sync + FILTER_LEN cycles. Byte pushed in cycle after stop-bit edge; visible in STATUS/kbd_irq one cycle later.

## Test plan
- Reset, read STATUS -> 0x0000_0000; read DATA -> 0x0000_0000; ACK one cycle each, kbd_irq=0.
- Frame 0x1C, parity 0, stop 1 (PS2C ~12 kHz) -> kbd_irq=1, STATUS=0x0000_0021; DATA read -> 0x0000_011C; STATUS -> 0x0.
- Frame 0x1C with parity 1 -> no push, STATUS=0x0000_0008; write 0x08 to STATUS -> STATUS=0x0. Stop=0 frame -> STATUS=0x0000_0010.
- 17 good frames 0x00..0x10, no reads -> STATUS=0x0000_0207; 16 DATA reads return 0x100..0x10F; 17th read -> 0x0; STATUS=0x0000_0004.
- Start + 4 bits then PS2C idle 2.5 ms -> no push, no flags; then frame 0xF0 -> DATA read 0x0000_01F0.
- STB held high 5 cycles on DATA with 2 bytes queued -> single ACK, one pop (count 2->1); RSTN pulsed low mid-frame -> all outputs 0, FIFO empty.
